// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   - rx_state_e : receiver frame states
//   - PAR_EVEN / PAR_ODD : parity mode selectors
//   - calc_div() : clocks per oversample tick for a given clock, baud and oversample ratio
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Integer divide rounds down; never return less than one clock per tick.
  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    int d;
    d = clk_freq / (baud * oversample);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: oversample tick generator shared by the UART receiver and transmitter.
// Ports:
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset
//   restart in  synchronous restart; the counter returns to 0 so the next tick
//               comes DIV clocks later
//   tick    out one-cycle pulse every DIV clocks
module uart_baud_gen #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // With DIV=1 the counter sits at 0 and tick is permanently high.
  assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver for 8-N/E/O-1 style frames, LSB first.
// Ports:
//   clk        in  system clock (rising edge)
//   rst_n      in  asynchronous active-low reset
//   rx         in  asynchronous serial line, idle high
//   rx_data    out last received data word, held until the next rx_valid
//   rx_valid   out one-cycle pulse per completed frame
//   parity_err out parity mismatch of the frame, qualified by rx_valid
//   frame_err  out stop bit sampled low, qualified by rx_valid
//   busy       out high from start-bit detection until the return to idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,   // even, >= 4
  parameter int DATA_BITS  = 8,    // 5..8
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic          PAR_SEL = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;
  localparam logic          HAS_PAR = (PARITY_EN != 0);

  // Synchroniser and edge-detect history; all idle high so reset is not a start edge.
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic rxs_prev_q, rxs_prev_d;
  logic rxs;

  rx_state_e state_q, state_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_q, perr_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;

  logic start_det;
  logic tick;

  assign rxs = sync2_q;

  uart_baud_gen #(
    .DIV (DIV)
  ) u_baud_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (start_det),
    .tick    (tick)
  );

  always_comb begin
    sync1_d    = rx;
    sync2_d    = sync1_q;
    rxs_prev_d = rxs;
  end

  always_comb begin
    state_d      = state_q;
    tcnt_d       = tcnt_q;
    bcnt_d       = bcnt_q;
    shreg_d      = shreg_q;
    perr_d       = perr_q;
    rx_data_d    = rx_data_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    rx_valid_d   = 1'b0;
    start_det    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Only a 1->0 transition starts a frame; a line held low never re-triggers.
        if (rxs_prev_q && !rxs) begin
          start_det = 1'b1;
          state_d   = ST_START;
          tcnt_d    = '0;
          bcnt_d    = '0;
          perr_d    = 1'b0;
        end
      end

      ST_START: begin
        if (tick) begin
          if (tcnt_q == T_MID) begin
            tcnt_d  = '0;
            // A start bit that is high again at mid-bit was a glitch.
            state_d = rxs ? ST_IDLE : ST_DATA;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end

      ST_DATA: begin
        if (tick) begin
          if (tcnt_q == T_END) begin
            tcnt_d  = '0;
            shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};
            if (bcnt_q == B_LAST) begin
              bcnt_d  = '0;
              state_d = HAS_PAR ? ST_PARITY : ST_STOP;
            end else begin
              bcnt_d = bcnt_q + BW'(1);
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end

      ST_PARITY: begin
        if (tick) begin
          if (tcnt_q == T_END) begin
            tcnt_d  = '0;
            perr_d  = (rxs != ((^shreg_q) ^ PAR_SEL));
            state_d = ST_STOP;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end

      ST_STOP: begin
        if (tick) begin
          if (tcnt_q == T_END) begin
            // Leave at mid-stop-bit; the remaining half bit is spent in idle,
            // which keeps back-to-back frames from being missed.
            tcnt_d       = '0;
            rx_data_d    = shreg_q;
            parity_err_d = perr_q;
            frame_err_d  = !rxs;
            rx_valid_d   = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      rxs_prev_q   <= 1'b1;
      state_q      <= ST_IDLE;
      tcnt_q       <= '0;
      bcnt_q       <= '0;
      shreg_q      <= '0;
      perr_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      rxs_prev_q   <= rxs_prev_d;
      state_q      <= state_d;
      tcnt_q       <= tcnt_d;
      bcnt_q       <= bcnt_d;
      shreg_q      <= shreg_d;
      perr_q       <= perr_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int OS       = 16;
  localparam int BIT_CLKS = 160;

  logic clk = 1'b0;
  logic rst_n;
  logic rx;

  logic [7:0] rx_data_e, rx_data_o;
  logic       rx_valid_e, rx_valid_o;
  logic       parity_err_e, parity_err_o;
  logic       frame_err_e, frame_err_o;
  logic       busy_e, busy_o;

  uart_rx #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS),
    .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)
  ) dut_e (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .rx_data(rx_data_e), .rx_valid(rx_valid_e),
    .parity_err(parity_err_e), .frame_err(frame_err_e), .busy(busy_e)
  );

  uart_rx #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS),
    .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1)
  ) dut_o (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .rx_data(rx_data_o), .rx_valid(rx_valid_o),
    .parity_err(parity_err_o), .frame_err(frame_err_o), .busy(busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Received frames packed as {frame_err, parity_err, data}.
  logic [9:0] got_e[$];
  logic [9:0] got_o[$];
  logic [9:0] exp_e[$];
  logic [9:0] exp_o[$];
  int vcyc_e    = -1;
  int busy_cnt  = 0;
  int t_start   = 0;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  always @(negedge clk) begin
    if (rx_valid_e) begin
      got_e.push_back({frame_err_e, parity_err_e, rx_data_e});
      vcyc_e = cyc;
    end
    if (rx_valid_o) got_o.push_back({frame_err_o, parity_err_o, rx_data_o});
    if (busy_e) busy_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Line-level transmitter plus reference model. podd=0 sends even parity,
  // podd=1 sends odd parity (i.e. the even bit inverted).
  task automatic send_frame(input logic [7:0] d, input bit podd, input bit stopb, input int bclk);
    bit pbit;
    pbit = (^d) ^ podd;
    exp_e.push_back({~stopb, (pbit != (^d)), d});
    exp_o.push_back({~stopb, (pbit != ~(^d)), d});
    rx = 1'b0;
    t_start = cyc;
    repeat (bclk) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (bclk) @(negedge clk);
    end
    rx = pbit;
    repeat (bclk) @(negedge clk);
    rx = stopb;
    repeat (bclk) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_frames(input string tag);
    chk({tag, "_count_even"}, got_e.size(), exp_e.size());
    chk({tag, "_count_odd"}, got_o.size(), exp_o.size());
    for (int i = 0; i < exp_e.size(); i++)
      if (i < got_e.size()) chk($sformatf("%s_even_%0d", tag, i), got_e[i], exp_e[i]);
    for (int i = 0; i < exp_o.size(); i++)
      if (i < got_o.size()) chk($sformatf("%s_odd_%0d", tag, i), got_o[i], exp_o[i]);
    got_e.delete(); got_o.delete(); exp_e.delete(); exp_o.delete();
  endtask

  initial begin
    logic [7:0] b2b [3];
    logic [7:0] rb;
    b2b[0] = 8'h00; b2b[1] = 8'hFF; b2b[2] = 8'h81;

    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_rx_data", rx_data_e, 0);
    chk("rst_rx_valid", rx_valid_e, 0);
    chk("rst_parity_err", parity_err_e, 0);
    chk("rst_frame_err", frame_err_e, 0);
    chk("rst_busy", busy_e, 0);
    rst_n = 1'b1;
    idle(20);

    // Even-parity 0xA5, nominal rate, latency from line edge (2 sync clocks + 1681).
    vcyc_e = -1;
    send_frame(8'hA5, 1'b0, 1'b1, BIT_CLKS);
    idle(40);
    chk("latency_A5", vcyc_e - t_start, 1683);
    check_frames("A5");

    // 0x3C with odd parity bit: even receiver flags it, odd receiver accepts it; then the reverse.
    send_frame(8'h3C, 1'b1, 1'b1, BIT_CLKS);
    idle(40);
    check_frames("3C_oddbit");
    send_frame(8'h3C, 1'b0, 1'b1, BIT_CLKS);
    idle(40);
    check_frames("3C_evenbit");

    // 0x55 with stop bit low, then line held low for 3 bit times.
    send_frame(8'h55, 1'b0, 1'b0, BIT_CLKS);
    rx = 1'b0;
    repeat (3 * BIT_CLKS) @(negedge clk);
    idle(300);
    check_frames("55_break");
    send_frame(8'h5A, 1'b0, 1'b1, BIT_CLKS);
    idle(40);
    check_frames("5A_after_break");

    // 60-clock glitch on an idle line.
    busy_cnt = 0;
    rx = 1'b0;
    repeat (60) @(negedge clk);
    idle(300);
    chk("glitch_busy_len", (busy_cnt >= 78 && busy_cnt <= 82), 1);
    check_frames("glitch");

    // Random bytes and parity choice, random idle gaps.
    for (int k = 0; k < 6; k++) begin
      rb = 8'($urandom_range(0, 255));
      send_frame(rb, 1'($urandom_range(0, 1)), 1'b1, BIT_CLKS);
      idle($urandom_range(0, 40));
    end
    idle(40);
    check_frames("random");

    // Back-to-back frames at +3 % and -3 % baud.
    for (int i = 0; i < 3; i++) send_frame(b2b[i], 1'b0, 1'b1, 155);
    idle(100);
    check_frames("b2b_fast");
    for (int i = 0; i < 3; i++) send_frame(b2b[i], 1'b1, 1'b1, 165);
    idle(100);
    check_frames("b2b_slow");

    // Reset during data bit 4 of 0x96.
    rb = 8'h96;
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = rb[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = rb[4];
    repeat (BIT_CLKS / 2) @(negedge clk);
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_rx_data", rx_data_e, 0);
    chk("abort_rx_valid", rx_valid_e, 0);
    chk("abort_busy", busy_e, 0);
    rst_n = 1'b1;
    idle(2 * BIT_CLKS);
    check_frames("abort_96");
    send_frame(8'h42, 1'b0, 1'b1, BIT_CLKS);
    idle(40);
    check_frames("42_after_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
